// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one data-memory requester (CPU or DMA).
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             we;
    logic [2:0]       mode;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req, we, mode, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, mode, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for the shared single-port data memory.
// Define DMEM_ARB_LOCK_EN to add cpu_lock/dma_lock for atomic back-to-back grants.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    dmem_arbiter_if.slave    cpu,
    dmem_arbiter_if.slave    dma,
`ifdef DMEM_ARB_LOCK_EN
    input  logic             cpu_lock,
    input  logic             dma_lock,
`endif
    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    output logic             mem_WE,
    output logic [2:0]       mem_modeAddr,
    input  logic [WIDTH-1:0] mem_RD
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             ld_q;
    logic             gnt_c;
    logic             gnt_d;
    logic             starve;
    logic             lock_c;
    logic             lock_d;

    assign starve = (wait_cnt == CNT_W'(MAX_WAIT));

`ifdef DMEM_ARB_LOCK_EN
    assign lock_c = (state == CPU) & cpu_lock & cpu.req;
    assign lock_d = (state == DMA) & dma_lock & dma.req;
`else
    assign lock_c = 1'b0;
    assign lock_d = 1'b0;
`endif

    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (!rst) begin
            if (lock_c)
                gnt_c = 1'b1;
            else if (lock_d)
                gnt_d = 1'b1;
            else if (dma.req && (!cpu.req || starve))
                gnt_d = 1'b1;
            else
                gnt_c = cpu.req;
        end
    end

    assign cpu.gnt = gnt_c;
    assign dma.gnt = gnt_d;

    // Idle cycles leave the CPU fields on the bus with WE low.
    always_comb begin
        unique case (1'b1)
            gnt_d: begin
                mem_A        = dma.addr;
                mem_WD       = dma.wdata;
                mem_modeAddr = dma.mode;
                mem_WE       = dma.we;
            end
            default: begin
                mem_A        = cpu.addr;
                mem_WD       = cpu.wdata;
                mem_modeAddr = cpu.mode;
                mem_WE       = gnt_c & cpu.we;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ld_q      <= 1'b0;
            cpu.rdata <= '0;
            dma.rdata <= '0;
        end else begin
            unique case (1'b1)
                gnt_c:   state <= CPU;
                gnt_d:   state <= DMA;
                default: state <= IDLE;
            endcase
            ld_q <= (gnt_c & ~cpu.we) | (gnt_d & ~dma.we);
            if (gnt_c & ~cpu.we)
                cpu.rdata <= mem_RD;
            if (gnt_d & ~dma.we)
                dma.rdata <= mem_RD;
            if (!dma.req || gnt_d)
                wait_cnt <= '0;
            else if (!starve)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // state names last cycle's owner, so rvalid is a pure flop decode.
    assign cpu.rvalid = ld_q & (state == CPU);
    assign dma.rvalid = ld_q & (state == DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter.
// Expected grants/data come from a spec-level model and a reference byte memory.
module tb_dmem_arbiter;

    localparam int W  = 32;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(W)) cpu_if ();
    dmem_arbiter_if #(.WIDTH(W)) dma_if ();

`ifdef DMEM_ARB_LOCK_EN
    logic cpu_lock = 1'b0;
    logic dma_lock = 1'b0;
`endif

    logic [W-1:0] mem_A;
    logic [W-1:0] mem_WD;
    logic         mem_WE;
    logic [2:0]   mem_modeAddr;
    logic [W-1:0] mem_RD;

    dmem_arbiter #(.WIDTH(W), .MAX_WAIT(MW), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (cpu_if),
        .dma          (dma_if),
`ifdef DMEM_ARB_LOCK_EN
        .cpu_lock     (cpu_lock),
        .dma_lock     (dma_lock),
`endif
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_WE       (mem_WE),
        .mem_modeAddr (mem_modeAddr),
        .mem_RD       (mem_RD)
    );

    // Byte memory: stores lay bytes low-first, loads assemble first byte as MSB.
    logic [7:0] phy_m [0:255];
    logic [7:0] ref_m [0:255];

    function automatic logic [31:0] ld(input logic [7:0] b0, b1, b2, b3,
                                       input logic [2:0] m);
        case (m)
            3'd1:    return {b0, b1, b2, b3};
            3'd2:    return {{16{b0[7]}}, b0, b1};
            3'd3:    return {{24{b0[7]}}, b0};
            3'd4:    return {16'h0, b0, b1};
            3'd5:    return {24'h0, b0};
            default: return 32'h0;
        endcase
    endfunction

    logic [7:0] pa;
    always_comb begin
        pa     = mem_A[7:0];
        mem_RD = ld(phy_m[pa], phy_m[pa + 8'd1], phy_m[pa + 8'd2],
                    phy_m[pa + 8'd3], mem_modeAddr);
    end

    always @(posedge clk) begin
        if (mem_WE) begin
            case (mem_modeAddr)
                3'd1: begin
                    phy_m[pa]        <= mem_WD[7:0];
                    phy_m[pa + 8'd1] <= mem_WD[15:8];
                    phy_m[pa + 8'd2] <= mem_WD[23:16];
                    phy_m[pa + 8'd3] <= mem_WD[31:24];
                end
                3'd2: begin
                    phy_m[pa]        <= mem_WD[7:0];
                    phy_m[pa + 8'd1] <= mem_WD[15:8];
                end
                3'd3: phy_m[pa] <= mem_WD[7:0];
                default: ;
            endcase
        end
    end

    task automatic ref_store(input logic [31:0] a, wd, input logic [2:0] m);
        logic [7:0] i;
        i = a[7:0];
        if (m == 3'd1 || m == 3'd2 || m == 3'd3) ref_m[i] = wd[7:0];
        if (m == 3'd1 || m == 3'd2) ref_m[i + 8'd1] = wd[15:8];
        if (m == 3'd1) begin
            ref_m[i + 8'd2] = wd[23:16];
            ref_m[i + 8'd3] = wd[31:24];
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a,
                                             input logic [2:0] m);
        logic [7:0] i;
        i = a[7:0];
        return ld(ref_m[i], ref_m[i + 8'd1], ref_m[i + 8'd2],
                  ref_m[i + 8'd3], m);
    endfunction

    typedef struct {
        bit          gc;
        bit          gd;
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  md;
        bit          rvc;
        bit          rvd;
        logic [31:0] hc;
        logic [31:0] hd;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] cq [$];
    logic [31:0] dq [$];

    int checks = 0;
    int errors = 0;

    // Model: refused = consecutive cycles DMA asked and lost; owner = last winner.
    int          refused = 0;
    int          owner   = 0;
    bit          m_rvc   = 0;
    bit          m_rvd   = 0;
    logic [31:0] m_hc    = '0;
    logic [31:0] m_hd    = '0;

    task automatic step();
        exp_t        e;
        bit          gc;
        bit          gd;
        bit          locked;
        logic [31:0] d;
        e.rvc  = m_rvc;
        e.rvd  = m_rvd;
        e.hc   = m_hc;
        e.hd   = m_hd;
        gc     = 0;
        gd     = 0;
        locked = 0;
        d      = '0;
        if (!rst) begin
`ifdef DMEM_ARB_LOCK_EN
            if (owner == 1 && cpu_lock && cpu_if.req) begin
                gc = 1; locked = 1;
            end else if (owner == 2 && dma_lock && dma_if.req) begin
                gd = 1; locked = 1;
            end
`endif
            if (!locked) begin
                if (dma_if.req && (!cpu_if.req || refused >= MW)) gd = 1;
                else if (cpu_if.req) gc = 1;
            end
        end
        e.gc = gc;
        e.gd = gd;
        e.we = 0;
        e.a  = cpu_if.addr;
        e.wd = cpu_if.wdata;
        e.md = cpu_if.mode;
        if (gd) begin
            e.we = dma_if.we;
            e.a  = dma_if.addr;
            e.wd = dma_if.wdata;
            e.md = dma_if.mode;
        end else if (gc) begin
            e.we = cpu_if.we;
        end
        if (gc || gd) begin
            if (e.we) ref_store(e.a, e.wd, e.md);
            else d = ref_load(e.a, e.md);
        end
        if (gc && !e.we) cq.push_back(d);
        if (gd && !e.we) dq.push_back(d);
        if (rst) begin
            m_rvc = 0; m_rvd = 0; m_hc = '0; m_hd = '0;
            refused = 0; owner = 0;
        end else begin
            m_rvc = gc && !e.we;
            m_rvd = gd && !e.we;
            if (m_rvc) m_hc = d;
            if (m_rvd) m_hd = d;
            if (dma_if.req && !gd) refused = (refused < MW) ? refused + 1 : MW;
            else refused = 0;
            owner = gc ? 1 : (gd ? 2 : 0);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (gc) cpu_if.req = 1'b0;
        if (gd) dma_if.req = 1'b0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] x;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cpu_gnt", {31'h0, cpu_if.gnt}, {31'h0, e.gc});
            chk("dma_gnt", {31'h0, dma_if.gnt}, {31'h0, e.gd});
            chk("mem_WE", {31'h0, mem_WE}, {31'h0, e.we});
            if (e.gc || e.gd) begin
                chk("mem_A", mem_A, e.a);
                chk("mem_WD", mem_WD, e.wd);
                chk("mem_mode", {29'h0, mem_modeAddr}, {29'h0, e.md});
            end
            chk("cpu_rvalid", {31'h0, cpu_if.rvalid}, {31'h0, e.rvc});
            chk("dma_rvalid", {31'h0, dma_if.rvalid}, {31'h0, e.rvd});
            if (e.rvc) begin
                x = (cq.size() > 0) ? cq.pop_front() : 32'hx;
                chk("cpu_rdata", cpu_if.rdata, x);
            end else begin
                chk("cpu_rdata_hold", cpu_if.rdata, e.hc);
            end
            if (e.rvd) begin
                x = (dq.size() > 0) ? dq.pop_front() : 32'hx;
                chk("dma_rdata", dma_if.rdata, x);
            end else begin
                chk("dma_rdata_hold", dma_if.rdata, e.hd);
            end
        end
    end

    task automatic put(input bit is_d, input bit we, input logic [2:0] md,
                       input logic [31:0] a, wd);
        if (is_d) begin
            dma_if.req = 1'b1; dma_if.we = we; dma_if.mode = md;
            dma_if.addr = a; dma_if.wdata = wd;
        end else begin
            cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.mode = md;
            cpu_if.addr = a; cpu_if.wdata = wd;
        end
    endtask

    task automatic rand_put(input bit is_d);
        bit          we;
        logic [2:0]  md;
        logic [31:0] off;
        we  = 1'($urandom_range(0, 1));
        md  = we ? 3'($urandom_range(1, 3)) : 3'($urandom_range(1, 5));
        off = 32'($urandom_range(0, 63));
        if (md == 3'd1) off = off & ~32'd3;
        if (md == 3'd2 || md == 3'd4) off = off & ~32'd1;
        put(is_d, we, md, 32'h10000 + off, $urandom);
    endtask

    task automatic run(input int n, input int pc, input int pd);
        for (int k = 0; k < n; k++) begin
            if (!cpu_if.req && $urandom_range(0, 99) < pc) rand_put(0);
            if (!dma_if.req && $urandom_range(0, 99) < pd) rand_put(1);
`ifdef DMEM_ARB_LOCK_EN
            cpu_lock = ($urandom_range(0, 3) == 0);
            dma_lock = ($urandom_range(0, 2) == 0);
`endif
            step();
        end
`ifdef DMEM_ARB_LOCK_EN
        cpu_lock = 1'b0;
        dma_lock = 1'b0;
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            phy_m[i] = 8'(i * 7 + 3);
            ref_m[i] = 8'(i * 7 + 3);
        end
        put(0, 0, 3'd1, 32'h10000, 32'h0);
        put(1, 0, 3'd1, 32'h10000, 32'h0);
        cpu_if.req = 1'b0;
        dma_if.req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        put(0, 1, 3'd1, 32'h10000, 32'hDEADBEEF);
        step();
        put(0, 0, 3'd1, 32'h10000, 32'h0);
        step();
        step();

        put(0, 0, 3'd1, 32'h10004, 32'h0);
        put(1, 0, 3'd1, 32'h10008, 32'h0);
        step();
        step();
        step();

        run(24, 100, 100);
        run(6, 0, 0);

        put(1, 1, 3'd3, 32'h10003, 32'h00000080);
        step();
        put(1, 0, 3'd5, 32'h10003, 32'h0);
        step();
        put(1, 0, 3'd3, 32'h10003, 32'h0);
        step();
        step();

        put(0, 1, 3'd1, 32'h10000, 32'h12345678);
        put(1, 0, 3'd1, 32'h10010, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cpu_if.req = 1'b0;
        dma_if.req = 1'b0;
        step();
        put(0, 0, 3'd1, 32'h10000, 32'h0);
        step();
        step();

        put(0, 1, 3'd0, 32'h10020, 32'hA5A5A5A5);
        step();
        step();

        run(300, 50, 50);
        run(300, 90, 90);
        run(300, 20, 80);
        run(8, 0, 0);

        @(negedge clk);
        #1;
        chk("cpu_q_empty", 32'(cq.size()), 32'd0);
        chk("dma_q_empty", 32'(dq.size()), 32'd0);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
